// File: rtl/fetch_pkg.sv
// Shared fetch types and constants.
// State encoding, default halt word, PC step and queue entry width.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

  localparam int XLEN = 32;
  localparam int QE_W = 2 * XLEN;

  localparam logic [XLEN-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] PC_INC        = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO with flush.
// Head always sits in mem[0]; pops shift mem[1] down.
module fetch_queue #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count,
  output logic         valid
);

  logic [W-1:0] mem [2];

  assign head_data = mem[0];
  assign valid     = (count != 2'd0);

  // Storage and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          mem[count[0]] <= push_data;
          count         <= count + 2'd1;
        end
        !push && pop: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        push && pop: begin
          if (count == 2'd1) begin
            mem[0] <= push_data;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, FSM, redirect and halt.
// Fetched {pc, word} pairs are buffered in fetch_queue.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              ADDR_W    = XLEN,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] HALT_WORD = ADDR_W'(HALT_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] Read_addres,
  input  logic [ADDR_W-1:0] instruccion,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PC0 =
    {RESET_PC[ADDR_W-1:2], 2'b00};

  state_t              state;
  state_t              nxt;
  logic [ADDR_W-1:0]   pc;
  logic [1:0]          count;
  logic [2*ADDR_W-1:0] head;
  logic                pop;
  logic                space;
  logic                push;
  logic                is_halt;

  assign Read_addres = pc;
  assign pop         = inst_valid & inst_ready;
  assign space       = (count != 2'd2) | pop;
  assign push        = (state == S_FETCH) & space & ~redirect;
  assign is_halt     = (instruccion == HALT_WORD);

  assign inst_pc  = head[2*ADDR_W-1:ADDR_W];
  assign inst_out = head[ADDR_W-1:0];

  // Next state; redirect overrides everything.
  always_comb begin
    nxt = state;
    if (redirect) begin
      nxt = en ? S_FETCH : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (en) nxt = S_FETCH;
        S_FETCH: begin
          if (push && is_halt) nxt = S_HALT;
          else if (!en)        nxt = S_IDLE;
          else if (!space)     nxt = S_HOLD;
        end
        S_HOLD: begin
          if (!en)       nxt = S_IDLE;
          else if (space) nxt = S_FETCH;
        end
        S_HALT:  nxt = S_HALT;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // State, PC and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= PC0;
      halted <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= nxt;
      halted <= (nxt == S_HALT);
      busy   <= (nxt == S_FETCH) || (nxt == S_HOLD);
      if (redirect) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (push && !is_halt) begin
        pc <= pc + ADDR_W'(PC_INC);
      end
    end
  end

  fetch_queue #(
    .W (2*ADDR_W)
  ) u_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({pc, instruccion}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .valid     (inst_valid)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl.
// Vector table for streaming/hold/redirect, hand sequences for the rest.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic        inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        halted;
  logic        busy;
  logic [31:0] Read_addres;
  logic [31:0] instruccion;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  bit          halt_en = 1'b0;
  logic [31:0] halt_addr = 32'hC;

  always #5 clk = ~clk;

  assign instruccion =
    (halt_en && Read_addres == halt_addr) ?
    32'hFFFF_FFFF : (Read_addres ^ 32'h1357_0000);

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (halt_en && a == halt_addr) ?
      32'hFFFF_FFFF : (a ^ 32'h1357_0000);
  endfunction

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .Read_addres (Read_addres),
    .instruccion (instruccion),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .halted      (halted),
    .busy        (busy)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    logic [31:0] ea;
    bit          ev;
    logic [31:0] ep;
    bit          eb;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input bit rst, input bit en_, input bit rdy,
    input bit rd, input logic [31:0] rpc,
    input logic [31:0] ea, input bit ev,
    input logic [31:0] ep, input bit eb);
    vec_t v;
    v.rst = rst; v.en = en_; v.rdy = rdy;
    v.rd = rd; v.rpc = rpc; v.ea = ea;
    v.ev = ev; v.ep = ep; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bit found;

    // streaming from reset
    vt.push_back(mk(1,1,1,0,0, 32'h0, 0,32'h0, 0));
    vt.push_back(mk(0,1,1,0,0, 32'h0, 0,32'h0, 1));
    vt.push_back(mk(0,1,1,0,0, 32'h4, 1,32'h0, 1));
    vt.push_back(mk(0,1,1,0,0, 32'h8, 1,32'h4, 1));
    vt.push_back(mk(0,1,1,0,0, 32'hC, 1,32'h8, 1));
    // backpressure, hold, then redirect while full
    vt.push_back(mk(1,1,0,0,0, 32'h0, 0,32'h0, 0));
    vt.push_back(mk(0,1,0,0,0, 32'h0, 0,32'h0, 1));
    vt.push_back(mk(0,1,0,0,0, 32'h4, 1,32'h0, 1));
    vt.push_back(mk(0,1,0,0,0, 32'h8, 1,32'h0, 1));
    vt.push_back(mk(0,1,0,0,0, 32'h8, 1,32'h0, 1));
    vt.push_back(mk(0,1,0,0,0, 32'h8, 1,32'h0, 1));
    vt.push_back(mk(0,1,1,0,0, 32'h8, 1,32'h0, 1));
    vt.push_back(mk(0,1,1,0,0, 32'h8, 1,32'h4, 1));
    vt.push_back(mk(0,1,1,0,0, 32'hC, 1,32'h8, 1));
    vt.push_back(mk(0,1,0,0,0, 32'h10,1,32'hC, 1));
    vt.push_back(mk(0,1,0,0,0, 32'h14,1,32'hC, 1));
    vt.push_back(mk(0,1,0,1,32'h42,
                    32'h14,1,32'hC, 1));
    vt.push_back(mk(0,1,1,0,0, 32'h40,0,32'h0, 1));
    vt.push_back(mk(0,1,1,0,0, 32'h44,1,32'h40,1));
    vt.push_back(mk(0,1,1,0,0, 32'h48,1,32'h44,1));

    // reset values before any clock
    #1;
    chk("rst valid", inst_valid, 0);
    chk("rst addr", Read_addres, 0);
    chk("rst out", inst_out, 0);
    chk("rst pc", inst_pc, 0);
    chk("rst halted", halted, 0);
    chk("rst busy", busy, 0);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      @(negedge clk);
      en = vt[i].en;
      inst_ready = vt[i].rdy;
      redirect = vt[i].rd;
      redirect_pc = vt[i].rpc;
      #1;
      chk($sformatf("v%0d addr", i), Read_addres, vt[i].ea);
      chk($sformatf("v%0d valid", i), inst_valid, vt[i].ev);
      chk($sformatf("v%0d busy", i), busy, vt[i].eb);
      chk($sformatf("v%0d halted", i), halted, 0);
      if (vt[i].ev) begin
        chk($sformatf("v%0d pc", i), inst_pc, vt[i].ep);
        chk($sformatf("v%0d out", i), inst_out,
            memw(vt[i].ep));
      end
    end

    // halt word at 0xC
    halt_en = 1'b1;
    do_reset();
    @(negedge clk);
    en = 1'b1;
    inst_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      found = inst_valid && (inst_pc == 32'hC);
    end
    chk("halt seen", found, 1);
    chk("halt out", inst_out, 32'hFFFF_FFFF);
    chk("halt flag", halted, 1);
    chk("halt addr", Read_addres, 32'hC);
    repeat (3) @(negedge clk);
    chk("halt drained", inst_valid, 0);
    chk("halt addr held", Read_addres, 32'hC);
    chk("halt flag held", halted, 1);
    chk("halt busy", busy, 0);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("unhalt addr", Read_addres, 32'h100);
    chk("unhalt flag", halted, 0);
    chk("unhalt busy", busy, 1);
    chk("unhalt valid0", inst_valid, 0);
    @(negedge clk);
    chk("unhalt valid", inst_valid, 1);
    chk("unhalt pc", inst_pc, 32'h100);
    chk("unhalt out", inst_out, memw(32'h100));

    // PC wrap
    halt_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap addr", Read_addres, 32'hFFFF_FFFC);
    chk("wrap flush", inst_valid, 0);
    @(negedge clk);
    chk("wrap pc0", inst_pc, 32'hFFFF_FFFC);
    chk("wrap valid0", inst_valid, 1);
    chk("wrap addr0", Read_addres, 32'h0);
    @(negedge clk);
    chk("wrap pc1", inst_pc, 32'h0);
    chk("wrap out1", inst_out, memw(32'h0));

    // async reset mid-stream
    @(negedge clk);
    chk("pre-rst valid", inst_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", inst_valid, 0);
    chk("arst addr", Read_addres, 0);
    chk("arst pc", inst_pc, 0);
    chk("arst out", inst_out, 0);
    chk("arst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle valid", inst_valid, 0);
    chk("idle addr", Read_addres, 0);
    en = 1'b1;
    @(negedge clk);
    chk("restart busy", busy, 1);
    chk("restart valid0", inst_valid, 0);
    @(negedge clk);
    chk("restart valid", inst_valid, 1);
    chk("restart pc", inst_pc, 0);
    chk("restart addr", Read_addres, 32'h4);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational instruction memory `instruccion_mem`.
- Owns the program counter and drives the memory's `Read_addres`.
- Captures the returned `instruccion` together with its PC into a 2-entry prefetch queue.
- Hands instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (with queue flush) and a halt word that stops fetching.

Parameters:
ADDR_W, 32, width of PC / Read_addres / instruction word
RESET_PC, 32'h0000_0000, PC loaded on reset (low 2 bits ignored, forced 0)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching after it is queued

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; sampled every cycle
Read_addres  out  ADDR_W  address to instruccion_mem; equals current PC
instruccion  in  ADDR_W  memory read data, combinational from Read_addres, same cycle
redirect  in  1  branch/jump taken; single-cycle pulse
redirect_pc  in  ADDR_W  target PC when redirect=1
inst_valid  out  1  queue head valid toward decode
inst_out  out  ADDR_W  queue head instruction
inst_pc  out  ADDR_W  PC of queue head instruction
inst_ready  in  1  decode accepts head when inst_valid & inst_ready
halted  out  1  FSM in HALT
busy  out  1  FSM in FETCH or HOLD

Behaviour:
Reset (async, rst_n=0):
- PC=RESET_PC&~3, queue empty, state IDLE.
- inst_valid=0, inst_out=0, inst_pc=0, halted=0, busy=0.
- Reset mid-operation discards queue contents and PC immediately, with no partial push.

Outputs:
- Read_addres = PC register, always driven, including in IDLE and HALT.
- inst_out/inst_pc come from registered queue storage, never combinationally from `instruccion`.

Definitions:
- pop = inst_valid & inst_ready.
- space = (count<2) | pop.
- push = (state==FETCH) & space & ~redirect. It writes {PC, instruccion} at the tail, then PC <= PC+4 (mod 2^ADDR_W; 32'hFFFF_FFFC wraps to 0).

FSM states:
- IDLE: no push. en=1 -> FETCH.
- FETCH: push whenever space.
  - en=0 -> IDLE. The push in that same cycle still occurs.
  - The pushed word equals HALT_WORD -> HALT. HALT_WORD is queued, and PC does not advance past it.
  - No space -> HOLD.
- HOLD: PC frozen, no push. Returns to FETCH once space (pop or count<2). en=0 -> IDLE.
- HALT: no push; halted=1. Queue continues draining. Only redirect leaves HALT, going to FETCH if en=1, else IDLE.

Redirect (highest priority):
- Queue flushed: count=0, inst_valid=0 next cycle. Any pop in that cycle is still honoured.
- PC <= redirect_pc & ~3. No push in the redirect cycle.
- Next state: FETCH if en=1, else IDLE. This applies from any state.

Queue:
- 2 entries, FIFO order. Simultaneous push+pop when full is legal; count unchanged.
- Pop when empty is impossible (inst_valid=0).

Latency:
- IDLE, en rises in cycle N -> FETCH in N+1; first push at end of N+1; inst_valid=1 in N+2.
- Redirect in cycle R -> target instruction valid in R+2.
- Steady-state throughput: 1 instr/cycle with inst_ready held high.

Decomposition:
- Shared package `fetch_pkg`: state encoding (IDLE, FETCH, HOLD, HALT), HALT_WORD, PC increment constant 4, queue entry width (2*ADDR_W).
- One natural sub-module: `fetch_queue`, a 2-entry synchronous FIFO with flush, push, pop, count, and async active-low reset. The FSM and PC stay in fetch_ctrl.
- instruccion_mem is instantiated at the top level, not inside this block.

Test Plan:
1. Reset then en=1, inst_ready=1, memory preloaded with words at 0x0,0x4,0x8 -> Read_addres 0,4,8,... on consecutive cycles; inst_valid first high 2 cycles after en; inst_pc sequence 0,4,8 with matching inst_out.
2. inst_ready=0 for 5 cycles -> queue holds 2 entries (pc 0,4); state HOLD; Read_addres frozen at 8. Raise inst_ready -> pc 0,4,8 delivered in order, with no duplicates or drops.
3. Redirect pulse with redirect_pc=0x0000_0042 while queue full -> next cycle inst_valid=0 and Read_addres=0x40. Stale entries never appear; inst_pc=0x40 valid 2 cycles after the pulse.
4. Memory word at 0xC = 32'hFFFF_FFFF -> that word is delivered with inst_pc=0xC; halted=1; Read_addres stays 0xC; no further pushes. Redirect to 0x100 -> fetching resumes at 0x100.
5. Redirect to 0xFFFF_FFFC -> delivered PCs are 0xFFFF_FFFC, then 0x0000_0000 (wrap).
6. Assert rst_n=0 asynchronously mid-stream with queue non-empty -> outputs reset immediately, without waiting for a clock edge: inst_valid=0, Read_addres=RESET_PC. Release -> IDLE until en.
